fht_ram_pingpong: RTL

- Parametrised successor to the fixed 4-bank FHT RAM array: N_BANK independent lanes, each holding two pages (ping/pong) of 2^A_BIT words of D_BIT bits.
- Lets the FHT butterfly engine read one frame while the next frame is loaded (ping-pong mode), or read and write one page in place between FHT stages (in-place mode).
- Adds read-valid pipelining, a configurable read latency, a page-swap control and write-first bypass for in-place hazards.
- Sits between the input loader/butterfly core and the output unloader.

---
 rtl/fht_ram_pingpong_pkg.sv | 25 ++
 rtl/fht_ram_pingpong_sdp.sv | 49 ++++
 rtl/fht_ram_pingpong.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fht_ram_pingpong_pkg.sv
// -----------------------------------------------------------------------------
// fht_ram_defs : shared definitions for the ping-pong FHT RAM array.
//   - access-mode encodings used on iMODE
//   - lane slice helper macro for the flattened per-lane buses
//   - legality check for the read-latency parameter
// -----------------------------------------------------------------------------
`ifndef FHT_RAM_DEFS_SV
`define FHT_RAM_DEFS_SV

// Part-select of lane k out of a flattened bus of w-bit lanes.
`define FHT_LANE(k, w) ((k) * (w)) +: (w)

package fht_ram_defs;

  localparam logic MODE_PINGPONG = 1'b0;
  localparam logic MODE_INPLACE  = 1'b1;

  // Only a bare RAM read (1) or RAM read plus output register (2) exist.
  function automatic logic rdLatLegal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

`endif

// File: rtl/fht_ram_pingpong_sdp.sv
// -----------------------------------------------------------------------------
// fht_ram_sdp : simple dual-port RAM, one write port and one registered read
// port. A same-address read/write in one cycle returns the old contents.
// Contents are never cleared; only the read register is reset.
//   iCLK      clock
//   iRESET    synchronous active-low reset (read register only)
//   iWE       write enable
//   iADDR_WR  write address
//   iDATA     write data
//   iRE       read enable
//   iADDR_RD  read address
//   oDATA     registered read data, held while iRE=0
// -----------------------------------------------------------------------------
module fht_ram_sdp #(
  parameter int D_BIT     = 17,
  parameter int DEPTH_BIT = 9
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iWE,
  input  logic [DEPTH_BIT-1:0] iADDR_WR,
  input  logic [D_BIT-1:0]     iDATA,
  input  logic                 iRE,
  input  logic [DEPTH_BIT-1:0] iADDR_RD,
  output logic [D_BIT-1:0]     oDATA
);

  logic [D_BIT-1:0] mem_r [0:(2**DEPTH_BIT)-1];
  logic [D_BIT-1:0] rdData_r;

  // Storage array write port.
  always_ff @(posedge iCLK) begin
    if (iWE) begin
      mem_r[iADDR_WR] <= iDATA;
    end
  end

  // Registered read port; non-blocking read gives old data on collision.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      rdData_r <= '0;
    end else if (iRE) begin
      rdData_r <= mem_r[iADDR_RD];
    end
  end

  assign oDATA = rdData_r;

endmodule

// File: rtl/fht_ram_pingpong.sv
// -----------------------------------------------------------------------------
// fht_ram_pingpong : N_BANK independent lanes, each holding two pages of
// 2^A_BIT words. Ping-pong mode writes page oPAGE while reading the other page;
// in-place mode reads and writes page oPAGE with write-first bypass.
//   iCLK      clock, rising edge
//   iRESET    synchronous active-low reset
//   iMODE     0 = ping-pong, 1 = in-place (per access cycle)
//   iSWAP     toggles oPAGE
//   iDATA     write data per lane
//   iADDR_WR  write address per lane
//   iADDR_RD  read address per lane
//   iWE       write enable per lane
//   iRE       read enable per lane
//   oDATA     read data per lane, held between valids
//   oVALID    per-lane single-cycle read-data valid, RD_LAT after issue
//   oPAGE     current write page
// -----------------------------------------------------------------------------
module fht_ram_pingpong
  import fht_ram_defs::*;
#(
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 8,
  parameter int N_BANK = 4,
  parameter int RD_LAT = 1
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iMODE,
  input  logic                      iSWAP,
  input  logic [N_BANK*D_BIT-1:0]   iDATA,
  input  logic [N_BANK*A_BIT-1:0]   iADDR_WR,
  input  logic [N_BANK*A_BIT-1:0]   iADDR_RD,
  input  logic [N_BANK-1:0]         iWE,
  input  logic [N_BANK-1:0]         iRE,
  output logic [N_BANK*D_BIT-1:0]   oDATA,
  output logic [N_BANK-1:0]         oVALID,
  output logic                      oPAGE
);

  if (!rdLatLegal(RD_LAT)) begin : gBadLat
    $error("fht_ram_pingpong: RD_LAT must be 1 or 2");
  end

  logic page_r;

  // Page register; reads/writes in a swap cycle still see the old page.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      page_r <= 1'b0;
    end else if (iSWAP) begin
      page_r <= ~page_r;
    end
  end

  assign oPAGE = page_r;

  for (genvar k = 0; k < N_BANK; k++) begin : gLane
    logic [A_BIT-1:0] wrAddr_s;
    logic [A_BIT-1:0] rdAddr_s;
    logic [D_BIT-1:0] wrData_s;
    logic [D_BIT-1:0] ramQ_s;
    logic [D_BIT-1:0] rdData_s;
    logic             we_s;
    logic             re_s;
    logic             rdPage_s;
    logic             hit_s;
    logic             vld1_r;
    logic             byp_r;
    logic [D_BIT-1:0] bypData_r;

    assign wrAddr_s = iADDR_WR[`FHT_LANE(k, A_BIT)];
    assign rdAddr_s = iADDR_RD[`FHT_LANE(k, A_BIT)];
    assign wrData_s = iDATA[`FHT_LANE(k, D_BIT)];

    // Accesses are suppressed while reset is held.
    assign we_s = iWE[k] & iRESET;
    assign re_s = iRE[k] & iRESET;

    // Read page and in-place write-first hazard detection for this lane.
    always_comb begin
      rdPage_s = (iMODE == MODE_INPLACE) ? page_r : ~page_r;
      hit_s    = (iMODE == MODE_INPLACE) && iWE[k] && iRE[k] &&
                 (wrAddr_s == rdAddr_s);
    end

    fht_ram_sdp #(
      .D_BIT    (D_BIT),
      .DEPTH_BIT(A_BIT + 1)
    ) uRam (
      .iCLK    (iCLK),
      .iRESET  (iRESET),
      .iWE     (we_s),
      .iADDR_WR({page_r, wrAddr_s}),
      .iDATA   (wrData_s),
      .iRE     (re_s),
      .iADDR_RD({rdPage_s, rdAddr_s}),
      .oDATA   (ramQ_s)
    );

    // First pipeline stage: valid plus bypass decision/data, updated only on
    // reads so the output mux holds its value between reads.
    always_ff @(posedge iCLK) begin
      if (!iRESET) begin
        vld1_r    <= 1'b0;
        byp_r     <= 1'b0;
        bypData_r <= '0;
      end else begin
        vld1_r <= iRE[k];
        if (iRE[k]) begin
          byp_r     <= hit_s;
          bypData_r <= wrData_s;
        end
      end
    end

    assign rdData_s = byp_r ? bypData_r : ramQ_s;

    if (RD_LAT == 2) begin : gOutReg
      logic             vld2_r;
      logic [D_BIT-1:0] out_r;

      // Optional output register stage, loaded only when data is valid.
      always_ff @(posedge iCLK) begin
        if (!iRESET) begin
          vld2_r <= 1'b0;
          out_r  <= '0;
        end else begin
          vld2_r <= vld1_r;
          if (vld1_r) begin
            out_r <= rdData_s;
          end
        end
      end

      assign oDATA[`FHT_LANE(k, D_BIT)] = out_r;
      assign oVALID[k]                  = vld2_r;
    end else begin : gNoOutReg
      assign oDATA[`FHT_LANE(k, D_BIT)] = rdData_s;
      assign oVALID[k]                  = vld1_r;
    end
  end

endmodule
